// File: rtl/mem_resp_pkg.sv
// Shared types and default sizing for the memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } resp_state_t;

  localparam int DEFAULT_DEPTH_LOG2 = 8;
  localparam int DEFAULT_LATENCY    = 4;

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port word RAM: synchronous write, registered read that holds between reads.
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // Array write port; contents are intentionally left untouched by reset.
  always_ff @(posedge clock) begin
    if (en && we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register only updates on a completed read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_r <= 32'd0;
    end else if (en && !we) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency load/store responder that stalls the CPU pipeline per access.
// Optional MEM_RESP_STATS_EN adds request and stall-cycle counters.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_ren,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        cache_stall,
  output logic        busy
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [31:0] stat_req_cnt,
  output logic [31:0] stat_stall_cnt
`endif
);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  resp_state_t           state_r;
  resp_state_t           state_s;
  logic [3:0]            lat_cnt_r;
  logic [3:0]            lat_cnt_s;
  logic                  start_s;
  logic                  access_s;
  logic                  stall_s;
  logic [DEPTH_LOG2-1:0] addr_r;
  logic [31:0]           wdata_r;
  logic                  wr_r;
  logic                  unused_addr_s;

  assign unused_addr_s = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

  // State and latency counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      lat_cnt_r <= 4'd0;
    end else begin
      state_r   <= state_s;
      lat_cnt_r <= lat_cnt_s;
    end
  end

  // Next-state, counter and stall decode.
  always_comb begin
    state_s   = state_r;
    lat_cnt_s = lat_cnt_r;
    start_s   = 1'b0;
    access_s  = 1'b0;
    stall_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_ren || req_wen) begin
          stall_s   = 1'b1;
          start_s   = 1'b1;
          state_s   = BUSY;
          lat_cnt_s = LAT_LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        if (lat_cnt_r == 4'd0) begin
          access_s = 1'b1;
          state_s  = DONE;
        end else begin
          lat_cnt_s = lat_cnt_r - 4'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s   = IDLE;
        lat_cnt_s = 4'd0;
      end
    endcase
  end

  // Capture the request at acceptance; later input changes are ignored.
  // A simultaneous read and write is latched as a write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_r  <= {DEPTH_LOG2{1'b0}};
      wdata_r <= 32'd0;
      wr_r    <= 1'b0;
    end else if (start_s) begin
      addr_r  <= req_addr[DEPTH_LOG2+1:2];
      wdata_r <= req_wdata;
      wr_r    <= req_wen;
    end
  end

  mem_resp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clock(clock),
    .reset(reset),
    .en   (access_s),
    .we   (wr_r),
    .addr (addr_r),
    .wdata(wdata_r),
    .rdata(rdata)
  );

  assign cache_stall = stall_s;
  assign busy        = (state_r != IDLE);

`ifdef MEM_RESP_STATS_EN
  logic [31:0] req_cnt_r;
  logic [31:0] stall_cnt_r;

  // Free-running, wrapping activity counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_cnt_r   <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (start_s) begin
        req_cnt_r <= req_cnt_r + 32'd1;
      end
      if (stall_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign stat_req_cnt   = req_cnt_r;
  assign stat_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (default LATENCY=4, DEPTH_LOG2=8).
module tb_mem_responder;

  localparam int STALL_CYCLES = 5;

  logic        clock;
  logic        reset;
  logic        req_ren;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        cache_stall;
  logic        busy;
`ifdef MEM_RESP_STATS_EN
  logic [31:0] stat_req_cnt;
  logic [31:0] stat_stall_cnt;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;
  int done_cnt = 0;
  int stall_run = 0;

  logic [31:0] model_mem [256];
  logic [31:0] model_rdata = 32'd0;
  logic [31:0] exp_rdata_q [$];
  string       exp_tag_q [$];

  mem_responder dut (
    .clock      (clock),
    .reset      (reset),
    .req_ren    (req_ren),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rdata      (rdata),
    .cache_stall(cache_stall),
    .busy       (busy)
`ifdef MEM_RESP_STATS_EN
    ,
    .stat_req_cnt  (stat_req_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    chk_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Monitor: measure each stall run and score the result in the DONE cycle.
  always @(negedge clock) begin
    if (!reset) begin
      stall_run = 0;
    end else if (cache_stall) begin
      stall_run++;
    end else if (busy) begin
      if (exp_rdata_q.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        string       tag;
        logic [31:0] exp_rd;
        tag    = exp_tag_q.pop_front();
        exp_rd = exp_rdata_q.pop_front();
        check_eq({tag, "_rdata"}, rdata, exp_rd);
        check_eq({tag, "_stall"}, 32'(stall_run), 32'(STALL_CYCLES));
      end
      done_cnt++;
      stall_run = 0;
    end else begin
      stall_run = 0;
    end
  end

  // Present one request, predict its result, and wait for the DONE cycle.
  task automatic do_access(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input string tag);
    int target;
    logic [7:0] idx;
    @(posedge clock);
    #1;
    req_ren   = ren;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    idx = addr[9:2];
    if (wen) model_mem[idx] = wdata;
    else     model_rdata = model_mem[idx];
    exp_rdata_q.push_back(model_rdata);
    exp_tag_q.push_back(tag);
    target = done_cnt + 1;
    for (int i = 0; i < 40 && done_cnt < target; i++) begin
      @(negedge clock);
      #1;
    end
    if (done_cnt < target) check_eq({tag, "_timeout"}, 32'(done_cnt), 32'(target));
  endtask

  task automatic release_req();
    @(posedge clock);
    #1;
    req_ren = 1'b0;
    req_wen = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req_ren = 1'b0;
    req_wen = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_stall", {31'd0, cache_stall}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    do_access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "st10");
    do_access(1'b0, 1'b1, 32'h0000_0014, 32'hCAFE_F00D, "st14");
    do_access(1'b1, 1'b0, 32'h0000_0014, 32'd0, "ld14");
    release_req();

    // Back-to-back loads separated only by the DONE cycle.
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'd0, "b2b_ld10");
    do_access(1'b1, 1'b0, 32'h0000_0014, 32'd0, "b2b_ld14");
    release_req();

    do_access(1'b1, 1'b0, 32'h0000_0413, 32'd0, "alias413");
    release_req();

    do_access(1'b1, 1'b1, 32'h0000_0020, 32'h0000_1234, "rw20");
    do_access(1'b1, 1'b0, 32'h0000_0020, 32'd0, "ld20");
    release_req();

    do_access(1'b0, 1'b1, 32'h0000_0030, 32'h1111_1111, "st30");
    release_req();

    // Store aborted by reset in its second BUSY cycle.
    @(posedge clock);
    #1;
    req_ren   = 1'b0;
    req_wen   = 1'b1;
    req_addr  = 32'h0000_0030;
    req_wdata = 32'h2222_2222;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    req_wen = 1'b0;
    @(negedge clock);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_stall", {31'd0, cache_stall}, 32'd0);
    check_eq("abort_rdata", rdata, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_rdata = 32'd0;

    do_access(1'b1, 1'b0, 32'h0000_0030, 32'd0, "ld30_after_abort");
    release_req();
    do_access(1'b0, 1'b1, 32'h0000_0034, 32'h5A5A_0F0F, "st34");
    release_req();
    do_access(1'b1, 1'b0, 32'h0000_0034, 32'd0, "ld34");
    release_req();

    @(negedge clock);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("queue_empty", 32'(exp_rdata_q.size()), 32'd0);
`ifdef MEM_RESP_STATS_EN
    check_eq("stat_req", stat_req_cnt, 32'd3);
    check_eq("stat_stall", stat_stall_cnt, 32'd15);
`endif

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
